sobel_window_gen: RTL
=====================

Name: sobel_window_gen

Overview:
- Producer side of the 72-bit 3x3 window interface consumed by the Sobel operator.
- Takes a raster-order 8-bit grayscale pixel stream and buffers two image lines, so that one 3x3 neighbourhood is presented per accepted pixel.
- Sits between the input pixel FIFO read side and the Sobel operator.
- Output image size equals input image size; windows touching the top or left border are zeroed.

Parameters:
- DWIDTH, 8, pixel width in bits.
- IMG_WIDTH, 720, pixels per line (minimum 3).
- IMG_HEIGHT, 540, lines per frame (minimum 3).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clock.
- in_pixel  in  DWIDTH  raster-order input pixel.
- in_valid  in  1  in_pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- out_window  out  9*DWIDTH  3x3 window; byte k = out_window[k*DWIDTH +: DWIDTH], k = r*3 + c. r=0 is the oldest line, c=0 is the oldest column.
- out_valid  out  1  out_window valid.
- out_ready  in  1  downstream accepts the window.
- out_last  out  1  qualifies the window produced by the final pixel of a frame.

Behaviour:
- Accept: acc = in_valid & in_ready.
- in_ready = !out_valid | out_ready. This is combinational and gives full throughput, one pixel per cycle.
- Counters:
  - col runs 0..IMG_WIDTH-1; row runs 0..IMG_HEIGHT-1; both width $clog2 of their limit.
  - On acc: col increments. At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At the last col of row IMG_HEIGHT-1, both wrap to 0 (next frame). No idle gap is required between frames.
- Line buffers:
  - lb0 holds line row-1 and lb1 holds line row-2, each IMG_WIDTH x DWIDTH.
  - On acc at column col: read lb0[col] and lb1[col] (old data), then write lb1[col] <= old lb0[col] and lb0[col] <= in_pixel.
  - Read-before-write on the same address in the same cycle is mandatory.
- Window registers:
  - 3x3 array w[r][c]. On acc, every row shifts left: w[r][0] <= w[r][1], w[r][1] <= w[r][2].
  - New column: w[0][2] <= lb1[col], w[1][2] <= lb0[col], w[2][2] <= in_pixel.
- Output register:
  - On acc: out_window <= packed new w, or all zeros if row < 2 or col < 2. Also out_valid <= 1 and out_last <= (row == IMG_HEIGHT-1 && col == IMG_WIDTH-1).
  - Else if out_ready: out_valid <= 0.
  - While out_valid & !out_ready, out_window, out_valid and out_last hold stable.
- Latency: the window for the pixel accepted at edge t is valid immediately after edge t (1 cycle).
- Count: exactly IMG_WIDTH*IMG_HEIGHT windows per frame.
- Reset values (reset==0 at edge):
  - out_valid=0, out_last=0, out_window=0, w=0, col=0, row=0.
  - Line buffer RAM is not cleared; stale contents are masked by the row<2 zeroing.
- Reset mid-frame: same as above. The next accepted pixel is treated as (row 0, col 0) of a new frame. No partial window is emitted.
- Simultaneous acc and out_ready with out_valid=1: the new window replaces the old one and out_valid stays 1.
- in_valid=0 cycles: no state change except out_valid clearing on out_ready.

Decomposition:
- Shared package constants:
  - PIX_W=8.
  - WIN_TAPS=9.
  - WIN_W=PIX_W*WIN_TAPS.
  - Window byte index function idx(r,c)=r*3+c.
  - Shared with the Sobel operator so both ends agree on packing.
- One sub-module: sobel_line_buffer.
  - Parameters: DEPTH and DWIDTH.
  - Ports: we, addr, din, dout (old data, read-before-write).
  - Instantiated twice (lb0, lb1), chained lb0.dout -> lb1.din.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, pixels 1..12 streamed with out_ready=1 -> 12 windows. Windows 1-10 (row<2 or col<2) are 0.
- Same stream, pixel 11 -> out_window = 0x0B0A09070605030201. Pixel 12 -> 0x0C0B0A080706040302 with out_last=1.
- Backpressure: out_ready=0 for 5 cycles after pixel 11 -> in_ready=0 during the stall, out_window holds 0x0B0A09070605030201, no pixel is lost, and pixel 12's window follows when out_ready=1.
- Two back-to-back frames (pixels 1..12 then 101..112) -> second frame rows 0-1 are zero. Pixel 111 -> 0x6F6E6D6B6A69676665.
- Reset pulled to 0 for 1 cycle after pixel 7 -> out_valid=0 the next cycle. Restart 1..12 reproduces the first-frame results exactly.
- Random in_valid/out_ready toggling, IMG_WIDTH=8, IMG_HEIGHT=5 -> every window matches a scoreboard model and out_last is asserted exactly once per 40 windows.

Source files
------------

// File: rtl/sobel_window_gen_pkg.sv
// ----------------------------------------------------------------------------
// sobel_window_gen_pkg
// Constants shared by the 3x3 window producer and the Sobel operator, so both
// ends agree on the width and byte ordering of the packed window.
//   PIX_W    : grayscale pixel width in bits
//   WIN_TAPS : number of pixels in a 3x3 window
//   WIN_W    : packed window width
//   idx(r,c) : byte slot of window element (r, c); r=0 oldest line, c=0 oldest column
// ----------------------------------------------------------------------------
package sobel_window_gen_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;
    localparam int WIN_W    = PIX_W * WIN_TAPS;

    function automatic int idx(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// ----------------------------------------------------------------------------
// sobel_line_buffer
// One image line of pixel storage with read-before-write semantics: dout
// always shows the contents at addr as they were before the current edge, so
// a write to the same address in the same cycle returns the old pixel.
//   clock : rising-edge clock
//   we    : write enable
//   addr  : column address
//   din   : pixel to store at addr
//   dout  : previous contents of addr (combinational read)
// ----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int DEPTH  = 720,
    parameter int DWIDTH = 8
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DWIDTH-1:0]          din,
    output logic [DWIDTH-1:0]          dout
);

    // Not reset: stale contents are masked downstream by the border zeroing.
    logic [DWIDTH-1:0] mem_q [DEPTH];

    assign dout = mem_q[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// ----------------------------------------------------------------------------
// sobel_window_gen
// Turns a raster-order pixel stream into one 3x3 neighbourhood per accepted
// pixel, using two line buffers and a 3x3 shift window. Windows touching the
// top two rows or left two columns are emitted as all zeros, so the output
// image has the same size as the input.
//   clock      : rising-edge clock
//   reset      : synchronous, active-low
//   in_pixel   : raster-order input pixel
//   in_valid   : in_pixel valid
//   in_ready   : a pixel can be accepted this cycle
//   out_window : packed 3x3 window, byte idx(r,c) = r*3+c
//   out_valid  : out_window valid
//   out_ready  : downstream takes the window
//   out_last   : window belongs to the last pixel of the frame
// ----------------------------------------------------------------------------
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int DWIDTH     = PIX_W,
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DWIDTH-1:0]            in_pixel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIN_TAPS*DWIDTH-1:0]   out_window,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]            col_q, col_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [DWIDTH-1:0]           w_q [3][3];
    logic [DWIDTH-1:0]           w_d [3][3];
    logic [WIN_TAPS*DWIDTH-1:0]  win_q, win_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;

    logic                        acc;
    logic                        border;
    logic [DWIDTH-1:0]           lb0_dout;
    logic [DWIDTH-1:0]           lb1_dout;

    // The output register can take a new window whenever it is empty or
    // being drained this cycle, giving one pixel per cycle.
    assign in_ready   = !out_valid_q | out_ready;
    assign acc        = in_valid & in_ready;
    assign out_window = win_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;

    // lb0 holds line row-1; its old pixel moves into lb1 (line row-2).
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DWIDTH(DWIDTH)) u_lb0 (
        .clock (clock),
        .we    (acc),
        .addr  (col_q),
        .din   (in_pixel),
        .dout  (lb0_dout)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DWIDTH(DWIDTH)) u_lb1 (
        .clock (clock),
        .we    (acc),
        .addr  (col_q),
        .din   (lb0_dout),
        .dout  (lb1_dout)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        w_d         = w_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        border      = (row_q < ROW_W'(2)) || (col_q < COL_W'(2));

        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                w_d[r][0] = w_q[r][1];
                w_d[r][1] = w_q[r][2];
            end
            w_d[0][2] = lb1_dout;
            w_d[1][2] = lb0_dout;
            w_d[2][2] = in_pixel;

            win_d = '0;
            if (!border) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win_d[idx(r, c)*DWIDTH +: DWIDTH] = w_d[r][c];
                    end
                end
            end
            out_valid_d = 1'b1;
            out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);

            // Raster counters; frames follow each other with no gap.
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            w_q         <= w_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
